pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
Parametrised successor to the fixed EX/MEM latch. It is a generic inter-stage pipeline register with a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, and synchronous flush with control-field kill. It is instantiated between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Stage-specific fields are packed into the data and control buses by the instantiating wrapper.

Parameters:
- DATA_W, 64: payload width (ALU result, store data, PC, ...); passes through unmodified.
- CTRL_W, 8: control bits (MemRead, MemWrite, RegWrite, MemtoReg, rd, ...); forced to zero on bubbles.
- CNT_W, 16: perf counter width; used only with PIPE_STAGE_BUF_PERF_EN.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: upstream stage presents an entry.
- in_ready, output, 1: this block can accept an entry.
- in_data, input, DATA_W: upstream payload.
- in_ctrl, input, CTRL_W: upstream control bits.
- flush, input, 1: synchronous kill of all held entries (branch mispredict/trap).
- out_valid, output, 1: entry presented downstream.
- out_ready, input, 1: downstream accepts (low = stall).
- out_data, output, DATA_W: head payload.
- out_ctrl, output, CTRL_W: head control bits; all zero whenever out_valid=0.
- stall_cnt, output, CNT_W: only with PIPE_STAGE_BUF_PERF_EN.
- flush_cnt, output, CNT_W: only with PIPE_STAGE_BUF_PERF_EN.

Behaviour:
- Reset (rst_n low, async): state EMPTY; out_valid=0, out_data=0, out_ctrl=0, skid regs=0, counters=0. in_ready=1 during reset, but no transfer is captured while rst_n is low.
- Transfers: input when in_valid&in_ready at a rising edge; output when out_valid&out_ready. Entries leave in arrival order; none are duplicated or dropped except by flush.
- All outputs are registered or decoded from state only. in_ready = (state!=FULL), with no combinational path from out_ready.
- Latency is 1 cycle, empty to out_valid. Throughput is 1 entry/cycle with out_ready held high.
- States (pipe_state_e):
  - EMPTY: in_valid -> BUSY, main<=in; otherwise stay.
  - BUSY (main valid, skid empty):
    - in_valid&out_ready -> BUSY, main<=in.
    - in_valid&!out_ready -> FULL, skid<=in.
    - !in_valid&out_ready -> EMPTY.
    - else hold.
  - FULL (main and skid valid; in_ready=0): out_ready -> BUSY, main<=skid; else hold. in_valid is ignored.
- Flush has highest priority. Next state is EMPTY, main and skid are invalidated, out_ctrl=0, and any same-cycle input is dropped. A same-cycle output transfer still counts as completed downstream. out_data holds its last value; it is don't-care while out_valid=0.
- Bubbles: whenever out_valid=0, out_ctrl=0, so a bubble can never write the register file or memory.
- Held stall: main and skid are stable while out_valid&!out_ready. The FULL->BUSY move happens only on an output transfer.
- Reset asserted mid-operation discards all entries immediately. The first accept after release gives out_valid on the next edge.

Optional Feature:
- Macro: PIPE_STAGE_BUF_PERF_EN.
- Defined: stall_cnt increments each cycle with out_valid&!out_ready. flush_cnt increments each cycle flush=1 while state!=EMPTY. Both saturate at all-ones, never wrap, and clear only on reset.
- Undefined: the ports, counters and logic are absent, and datapath behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - typedef enum logic [1:0] pipe_state_e {EMPTY=2'b00, BUSY=2'b01, FULL=2'b10}.
  - localparams XLEN=32 and REG_ADDR_W=5.
  - Standard CTRL_W bit positions: MEMREAD=0, MEMWRITE=1, REGWRITE=2, MEMTOREG=3, RD=[8:4] when CTRL_W>=9.
- One sub-module, sat_counter (width-parametrised saturating counter, async active-low reset), instantiated twice under the macro.

Test Plan:
- Reset then stream: in_valid=1 for 4 cycles with in_data=1,2,3,4 and out_ready=1 -> out_valid rises 1 cycle after the first accept; outputs 1,2,3,4 on consecutive cycles; in_ready stays 1.
- Back-pressure: stream 0xA,0xB,0xC with out_ready=0 from cycle 2 -> 0xA held, 0xB in skid, in_ready=0. Raise out_ready -> 0xA,0xB,0xC in order, no loss or duplication.
- Flush while FULL: flush=1 with in_valid=1 (data 0xD) -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and 0xD never appears.
- Bubble kill: in_ctrl=8'hFF and in_valid=0 after a drain -> out_ctrl=0 every cycle with out_valid=0.
- Async reset mid-stall: drop rst_n between edges while FULL -> out_valid=0 immediately, before the next clk edge. After release, the first accepted entry 0x55 appears 1 cycle later.
- With PIPE_STAGE_BUF_PERF_EN and CNT_W=4: stall for 20 cycles -> stall_cnt=15 (saturated); one flush while BUSY -> flush_cnt=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline register.
// Control-bus bit positions are the ones stage wrappers use when packing in_ctrl.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } pipe_state_e;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam int CTRL_MEMREAD  = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_REGWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_RD_LSB   = 4;
  localparam int CTRL_RD_MSB   = CTRL_RD_LSB + REG_ADDR_W - 1;

  // The rd field only exists when the control bus is wide enough to hold it.
  function automatic logic ctrl_has_rd(input int ctrl_w);
    return ctrl_w > CTRL_RD_MSB;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parametrised up-counter that sticks at all-ones instead of wrapping.
// Cleared only by the asynchronous active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic valid/ready pipeline register with a 2-entry skid buffer and flush.
// Optional perf counters (stall_cnt, flush_cnt) are built with PIPE_STAGE_BUF_PERF_EN.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_BUF_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  pipe_state_e       r_state;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  // Control fields are zeroed whenever an entry is killed or leaves, so a
  // bubble presents out_ctrl=0 straight from the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (in_valid) begin
            r_state     <= BUSY;
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end
        end
        BUSY: begin
          if (in_valid && out_ready) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (in_valid) begin
            r_state     <= FULL;
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
          end else if (out_ready) begin
            r_state     <= EMPTY;
            r_main_ctrl <= '0;
          end
        end
        FULL: begin
          if (out_ready) begin
            r_state     <= BUSY;
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_skid_ctrl <= '0;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_main_ctrl <= '0;
          r_skid_ctrl <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = out_valid && !out_ready;
  assign w_flush_inc = flush && (r_state != EMPTY);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_flush_inc),
    .o_count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (perf checks need PIPE_STAGE_BUF_PERF_EN).
// Inputs change 1ns after each rising edge; outputs are checked at that same point.
module tb_pipe_stage_buf;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pipe_stage_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("[%0t] check %s observed=0x%0h expected=0x%0h", $time, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] c, input logic rdy);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = rdy;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b1, 64'h99, 8'hFF, 1'b1);

    // Reset with in_valid high: nothing may be captured
    tick(); tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data",  out_data, 64'd0);
    check("rst_out_ctrl",  {56'd0, out_ctrl}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    drive(1'b0, 64'h0, 8'h0, 1'b1);
    rst_n = 1'b1;
    tick();
    check("rst_rel_out_valid", {63'd0, out_valid}, 64'd0);

    // Stream 1..4 with out_ready high
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 64'(i), 8'(8'h10 + i), 1'b1);
      tick();
      check("stream_valid", {63'd0, out_valid}, 64'd1);
      check("stream_data",  out_data, 64'(i));
      check("stream_ctrl",  {56'd0, out_ctrl}, 64'(8'h10 + i));
      check("stream_ready", {63'd0, in_ready}, 64'd1);
    end
    drive(1'b0, 64'h0, 8'h0, 1'b1);
    tick();
    check("drain_valid", {63'd0, out_valid}, 64'd0);
    check("drain_ctrl",  {56'd0, out_ctrl}, 64'd0);

    // Back-pressure: A,B,C with out_ready low from cycle 2
    drive(1'b1, 64'hA, 8'h0A, 1'b0);
    tick();
    check("bp_a_valid", {63'd0, out_valid}, 64'd1);
    check("bp_a_data",  out_data, 64'hA);
    drive(1'b1, 64'hB, 8'h0B, 1'b0);
    tick();
    check("bp_full_data",  out_data, 64'hA);
    check("bp_full_ready", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 64'hC, 8'h0C, 1'b0);
    tick();
    check("bp_hold_data",  out_data, 64'hA);
    check("bp_hold_ctrl",  {56'd0, out_ctrl}, 64'h0A);
    check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 64'hC, 8'h0C, 1'b1);
    tick();
    check("bp_b_data",  out_data, 64'hB);
    check("bp_b_ctrl",  {56'd0, out_ctrl}, 64'h0B);
    check("bp_b_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check("bp_c_data",  out_data, 64'hC);
    check("bp_c_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b0, 64'h0, 8'h0, 1'b1);
    tick();
    check("bp_empty_valid", {63'd0, out_valid}, 64'd0);

    // Flush while FULL, same-cycle input 0xD dropped
    drive(1'b1, 64'hA1, 8'h11, 1'b0);
    tick();
    drive(1'b1, 64'hA2, 8'h12, 1'b0);
    tick();
    check("fl_pre_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    drive(1'b1, 64'hD, 8'h0D, 1'b0);
    tick();
    flush = 1'b0;
    check("fl_valid", {63'd0, out_valid}, 64'd0);
    check("fl_ctrl",  {56'd0, out_ctrl}, 64'd0);
    check("fl_ready", {63'd0, in_ready}, 64'd1);

    // Bubble kill: in_ctrl all ones but in_valid low
    drive(1'b0, 64'hD, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bub_valid", {63'd0, out_valid}, 64'd0);
      check("bub_ctrl",  {56'd0, out_ctrl}, 64'd0);
    end

    // Async reset while FULL, then recovery with 0x55
    drive(1'b1, 64'h31, 8'h5A, 1'b0);
    tick();
    drive(1'b1, 64'h32, 8'h5B, 1'b0);
    tick();
    check("ar_pre_valid", {63'd0, out_valid}, 64'd1);
    check("ar_pre_ready", {63'd0, in_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid_now", {63'd0, out_valid}, 64'd0);
    check("ar_ctrl_now",  {56'd0, out_ctrl}, 64'd0);
    check("ar_ready_now", {63'd0, in_ready}, 64'd1);
    tick();
    drive(1'b1, 64'h55, 8'h33, 1'b1);
    rst_n = 1'b1;
    tick();
    check("ar_rec_valid", {63'd0, out_valid}, 64'd1);
    check("ar_rec_data",  out_data, 64'h55);
    check("ar_rec_ctrl",  {56'd0, out_ctrl}, 64'h33);

`ifdef PIPE_STAGE_BUF_PERF_EN
    // Counters cleared by the reset above; 20 stall cycles saturate a 4-bit counter
    drive(1'b0, 64'h0, 8'h0, 1'b0);
    check("pf_stall_zero", {60'd0, stall_cnt}, 64'd0);
    for (int i = 0; i < 20; i++) tick();
    check("pf_stall_sat", {60'd0, stall_cnt}, 64'd15);
    check("pf_flush_zero", {60'd0, flush_cnt}, 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("pf_flush_one", {60'd0, flush_cnt}, 64'd1);
    tick();
    check("pf_flush_empty", {60'd0, flush_cnt}, 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
